// File: rtl/key_press_classifier.sv
// Synchronises and debounces one active-low push-button, then classifies each press as short/long.
// Optional auto-repeat while a long press is held: define KEY_AUTOREPEAT_EN.
module key_press_classifier #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CYC     = 50_000_000,
   parameter int REPEAT_CYC   = 10_000_000,
   parameter int CNT_W        = 28
) (
   input  logic       FPGA_CLK,
   input  logic       RESET_BUT,
   input  logic       KEY,
   output logic       key_level,
   output logic       short_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, HELD = 2'd2} state_t;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);

   logic             key_s1, key_s2;
   logic [CNT_W-1:0] deb_cnt;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic             short_nxt, long_nxt;

   always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
      if (!RESET_BUT) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= KEY;
         key_s2 <= key_s1;
      end
   end

   // key_level holds the debounced state directly (pressed = 1), so no extra output stage delay.
   always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
      if (!RESET_BUT) begin
         deb_cnt   <= '0;
         key_level <= 1'b0;
      end else if (~key_s2 == key_level) begin
         deb_cnt <= '0;
      end else if (deb_cnt >= DEB_LAST) begin
         key_level <= ~key_level;
         deb_cnt   <= '0;
      end else begin
         deb_cnt <= deb_cnt + ONE;
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
   logic [CNT_W-1:0] rep_cnt, rep_nxt;
   logic             rep_pulse_nxt;
`endif

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      short_nxt = 1'b0;
      long_nxt  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_nxt       = rep_cnt;
      rep_pulse_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            hold_nxt = '0;
            // The rise cycle itself is hold cycle 0, so PRESSED starts at 1.
            if (key_level) begin
               state_nxt = PRESSED;
               hold_nxt  = ONE;
            end
         end
         PRESSED: begin
            if (hold_cnt >= HOLD_LAST) begin
               state_nxt = HELD;
               long_nxt  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
               rep_nxt   = '0;
`endif
            end else if (!key_level) begin
               state_nxt = IDLE;
               short_nxt = 1'b1;
            end else begin
               hold_nxt = hold_cnt + ONE;
            end
         end
         HELD: begin
            if (!key_level) begin
               state_nxt = IDLE;
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (rep_cnt >= REP_LAST) begin
               rep_pulse_nxt = 1'b1;
               rep_nxt       = '0;
            end else begin
               rep_nxt = rep_cnt + ONE;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
      if (!RESET_BUT) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         short_pulse <= 1'b0;
         long_pulse  <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_nxt;
         short_pulse <= short_nxt;
         long_pulse  <= long_nxt;
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
      if (!RESET_BUT) begin
         rep_cnt      <= '0;
         repeat_pulse <= 1'b0;
      end else begin
         rep_cnt      <= rep_nxt;
         repeat_pulse <= rep_pulse_nxt;
      end
   end
`else
   assign repeat_pulse = 1'b0;
`endif

   assign fsm_state = state;

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier with DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5.
// A timeline model (key history -> level -> pulse times) checks every cycle.
module tb_key_press_classifier;
   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int REP  = 5;
   localparam int CW   = 8;
`ifdef KEY_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key = 1'b0;
   logic       key_level, short_pulse, long_pulse, repeat_pulse;
   logic [1:0] fsm_state;

   always #5 clk = ~clk;

   key_press_classifier #(
      .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .REPEAT_CYC(REP), .CNT_W(CW)
   ) dut (
      .FPGA_CLK(clk), .RESET_BUT(rst_n), .KEY(key),
      .key_level(key_level), .short_pulse(short_pulse), .long_pulse(long_pulse),
      .repeat_pulse(repeat_pulse), .fsm_state(fsm_state)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Reference timeline: key_h[t] = KEY during cycle t since reset release
   int  key_h[$];
   int  t;
   bit  lvl_m;
   int  last_rise, last_fall;
   bit  e_lvl, e_short, e_long, e_rep;
   int  cnt_short, cnt_long, cnt_rep, cnt_rise;
   bit  lvl_d;

   function automatic int kv(input int idx);
      if (idx < 0) return 1;
      return key_h[idx];
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_level", key_level, 0);
         check("rst_short", short_pulse, 0);
         check("rst_long", long_pulse, 0);
         check("rst_repeat", repeat_pulse, 0);
         key_h.delete();
         t = 0; lvl_m = 0; lvl_d = 0;
         last_rise = -1000; last_fall = -1000;
      end else begin
         int  v, d;
         bit  same;
         key_h.push_back(int'(key));
         // Level flips once the sampled key held the opposite value for DEB cycles.
         e_lvl = lvl_m;
         v = kv(t - 3);
         same = 1;
         for (int i = 3; i <= DEB + 2; i++) if (kv(t - i) != v) same = 0;
         if (same && ((v == 0) != lvl_m)) e_lvl = (v == 0);
         e_long  = (last_rise == t - LONG) && (last_fall < last_rise || last_fall == t - 1);
         e_short = (last_fall == t - 1) && (last_fall > last_rise) && (last_fall - last_rise <= LONG - 2);
         d = t - last_rise - LONG;
         e_rep = AR && (last_fall < last_rise) && (d > 0) && (d % REP == 0);
         check("level", key_level, e_lvl);
         check("short", short_pulse, e_short);
         check("long", long_pulse, e_long);
         check("repeat", repeat_pulse, e_rep);
         if (e_lvl && !lvl_m) last_rise = t;
         if (!e_lvl && lvl_m) last_fall = t;
         lvl_m = e_lvl;
         t++;
         cnt_short += int'(short_pulse);
         cnt_long  += int'(long_pulse);
         cnt_rep   += int'(repeat_pulse);
         if (key_level && !lvl_d) cnt_rise++;
         lvl_d = key_level;
      end
   end

   typedef struct {
      int press;
      int e_short;
      int e_long;
      int e_rep;
   } press_rec_t;

   logic [11:0] exp_q[$];

   task automatic clear_counts();
      cnt_short = 0; cnt_long = 0; cnt_rep = 0; cnt_rise = 0;
   endtask

   initial begin
      press_rec_t  tbl[8];
      logic [11:0] e;
      tbl[0] = '{10, 1, 0, 0};
      tbl[1] = '{32, 0, 1, AR ? 2 : 0};
      tbl[2] = '{19, 0, 1, 0};
      tbl[3] = '{18, 1, 0, 0};
      tbl[4] = '{25, 0, 1, AR ? 1 : 0};
      tbl[5] = '{24, 0, 1, 0};
      tbl[6] = '{DEB, 1, 0, 0};
      tbl[7] = '{29, 0, 1, AR ? 1 : 0};

      // Reset held with key pressed, then level rises 6 cycles after release
      rst_n = 0; key = 0;
      step(3);
      check("reset_outputs", {key_level, short_pulse, long_pulse, repeat_pulse}, 0);
      rst_n = 1;
      step(5);
      check("reset_rise_early", key_level, 0);
      step(1);
      check("reset_rise", key_level, 1);
      step(4);
      key = 1;
      step(20);

      // Bounce
      clear_counts();
      for (int i = 0; i < 6; i++) begin
         key = ~key;
         step(2);
      end
      key = 0;
      step(5);
      check("bounce_early", key_level, 0);
      check("bounce_no_strobe", cnt_short + cnt_long + cnt_rep, 0);
      step(1);
      check("bounce_rise", key_level, 1);
      step(8);
      check("bounce_single_rise", cnt_rise, 1);
      key = 1;
      step(20);

      // Table of press durations (key_level high for exactly 'press' cycles)
      foreach (tbl[i]) begin
         clear_counts();
         key = 0;
         step(tbl[i].press);
         key = 1;
         step(16);
         exp_q.push_back({4'(tbl[i].e_short), 4'(tbl[i].e_long), 4'(tbl[i].e_rep)});
         e = exp_q.pop_front();
         check($sformatf("tbl%0d_short", i), cnt_short, e[11:8]);
         check($sformatf("tbl%0d_long", i), cnt_long, e[7:4]);
         check($sformatf("tbl%0d_repeat", i), cnt_rep, e[3:0]);
      end

      // Reset at hold cycle 12, key released while in reset
      key = 0;
      step(DEB + 2 + 12);
      check("midpress_level_before", key_level, 1);
      rst_n = 0;
      #1;
      check("midpress_reset_outputs", {key_level, short_pulse, long_pulse, repeat_pulse}, 0);
      step(1);
      key = 1;
      step(2);
      rst_n = 1;
      clear_counts();
      step(40);
      check("midpress_no_strobe", cnt_short + cnt_long + cnt_rep, 0);
      check("midpress_no_rise", cnt_rise, 0);

      // Random segments of key level and duration
      for (int i = 0; i < 80; i++) begin
         key = 1'($urandom_range(0, 1));
         step($urandom_range(1, 30));
      end
      key = 1;
      step(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
